// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 device. The host first inhibits the
// line clock, then issues a request-to-send (data low, clock released).
// After that it shifts out 8 data bits (LSB first), an odd parity bit and
// a stop bit, each on a device-generated falling clock edge. Finally it
// samples the device acknowledge bit.
//
// Parameters:
//   INHIBIT_CYCLES  clock-inhibit duration in clk cycles (default 5000)
//   TIMEOUT_CYCLES  transfer watchdog limit in clk cycles (default 750000)
//
// Optional build macro:
//   PS2_HOST_TX_TIMEOUT_EN  builds a watchdog. The count starts when
//                           INHIBIT ends. If it reaches TIMEOUT_CYCLES
//                           before the transfer completes, the transfer is
//                           aborted with error set. Without the macro, a
//                           silent device leaves busy set until reset.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   stb          bus access strobe (one cycle per access)
//   we           1 = write (start transmit), 0 = read status
//   data_in      command byte to transmit
//   data_out     status {5'b0, done, error, busy}
//   irq          one-cycle pulse at transfer end
//   ps2_clk_in   raw PS/2 clock line level (asynchronous)
//   ps2_data_in  raw PS/2 data line level (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
`timescale 1ns/1ps

module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stb,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SEND,
    ACK,
    WAITHIGH
  } stateT;

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  // Counter value at the start of the final inhibit cycle.
  localparam logic [INH_W-1:0] INH_DATA =
    INH_W'((INHIBIT_CYCLES >= 2) ? (INHIBIT_CYCLES - 2) : 0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wdCnt;
`endif

  stateT            state;
  logic [1:0]       clkSync;
  logic [1:0]       dataSync;
  logic             clkFilt;
  logic             dataFilt;
  logic             fallEdge;
  logic [7:0]       shiftReg;
  logic             parityBit;
  logic [3:0]       bitCnt;
  logic [INH_W-1:0] inhCnt;
  logic             busy;
  logic             done;
  logic             error;
  logic             acked;

  assign data_out = {5'b0, done, error, busy};

  // The filtered level changes only when the last two synchronized samples
  // agree. As a result, a pulse lasting a single clk cycle never produces
  // an edge.
  assign fallEdge = clkFilt & ~clkSync[1] & ~clkSync[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      clkSync     <= '1;
      dataSync    <= '1;
      clkFilt     <= 1'b1;
      dataFilt    <= 1'b1;
      shiftReg    <= '0;
      parityBit   <= 1'b0;
      bitCnt      <= '0;
      inhCnt      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      acked       <= 1'b0;
      irq         <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wdCnt       <= '0;
`endif
    end else begin
      clkSync  <= {clkSync[0], ps2_clk_in};
      dataSync <= {dataSync[0], ps2_data_in};
      if (clkSync[1] == clkSync[0]) clkFilt <= clkSync[1];
      if (dataSync[1] == dataSync[0]) dataFilt <= dataSync[1];
      irq <= 1'b0;

      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (stb && we) begin
            shiftReg    <= data_in;
            parityBit   <= ~^data_in;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            acked       <= 1'b0;
            inhCnt      <= '0;
            bitCnt      <= '0;
            ps2_clk_oe  <= 1'b1;
            // A one-cycle inhibit is also its own last cycle.
            ps2_data_oe <= (INHIBIT_CYCLES < 2);
            state       <= INHIBIT;
          end
        end

        INHIBIT: begin
          inhCnt <= inhCnt + 1'b1;
          if (inhCnt == INH_DATA) ps2_data_oe <= 1'b1;
          if (inhCnt == INH_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            bitCnt      <= '0;
            state       <= REQUEST;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wdCnt       <= '0;
`endif
          end
        end

        // REQUEST lasts only one cycle. It still honours a falling edge so
        // that an early device clock is not lost.
        REQUEST, SEND: begin
          if (state == REQUEST) state <= SEND;
          if (fallEdge) begin
            bitCnt <= bitCnt + 4'd1;
            if (bitCnt < 4'd8) begin
              ps2_data_oe <= ~shiftReg[bitCnt[2:0]];
            end else if (bitCnt == 4'd8) begin
              ps2_data_oe <= ~parityBit;
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
        end

        ACK: begin
          if (fallEdge) begin
            if (dataFilt) error <= 1'b1;
            acked <= ~dataFilt;
            state <= WAITHIGH;
          end
        end

        WAITHIGH: begin
          if (clkFilt && dataFilt) begin
            busy  <= 1'b0;
            done  <= acked;
            irq   <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // The watchdog overrides any normal progress made in the same cycle.
      if (state == REQUEST || state == SEND || state == ACK || state == WAITHIGH) begin
        if (wdCnt == WD_LAST) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          error       <= 1'b1;
          done        <= 1'b0;
          busy        <= 1'b0;
          irq         <= 1'b1;
          state       <= IDLE;
        end else begin
          wdCnt <= wdCnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed testbench for ps2_host_tx with a PS/2 device model.
`timescale 1ns/1ps

module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       stb = 1'b0;
  logic       we = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic [7:0] dataOut;
  logic       irq;
  logic       clkOe;
  logic       dataOe;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;
  wire        ps2ClkLine  = devClk & ~clkOe;
  wire        ps2DataLine = devData & ~dataOe;

  int checks = 0;
  int failures = 0;
  int irqCount = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(5000),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clk        (clk),
    .reset      (resetN),
    .stb        (stb),
    .we         (we),
    .data_in    (dataIn),
    .data_out   (dataOut),
    .irq        (irq),
    .ps2_clk_in (ps2ClkLine),
    .ps2_data_in(ps2DataLine),
    .ps2_clk_oe (clkOe),
    .ps2_data_oe(dataOe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (irq === 1'b1) irqCount++;

  task automatic hostWrite(input logic [7:0] v);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; dataIn = v;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  // Device model. It waits for the request-to-send and then clocks nEdges
  // falling edges. The line level is captured before each rising edge:
  // bits[0] is the start bit, bits[1..8] the data, bits[9] the parity and
  // bits[10] the stop bit. Edge 11 is the acknowledge bit.
  task automatic deviceRun(input int nEdges, input bit ackLow, input int midEdge,
                           input logic [7:0] midVal, output logic [10:0] bits,
                           output logic [7:0] midStatus, output bit tmo);
    int n;
    tmo = 1'b0; bits = '1; midStatus = '0; n = 0;
    while (!(clkOe === 1'b0 && dataOe === 1'b1) && n < 10000) begin
      @(negedge clk); n++;
    end
    if (n >= 10000) begin
      tmo = 1'b1;
      return;
    end
    repeat (10) @(negedge clk);
    bits[0] = ps2DataLine;
    for (int e = 1; e <= nEdges; e++) begin
      if (e == 11) begin
        devData = ackLow ? 1'b0 : 1'b1;
        repeat (10) @(negedge clk);
      end
      devClk = 1'b0;
      repeat (10) @(negedge clk);
      if (e == midEdge) begin
        hostWrite(midVal);
        midStatus = dataOut;
      end
      if (e <= 10) bits[e] = ps2DataLine;
      devClk = 1'b1;
      repeat (10) @(negedge clk);
      if (e == 11) devData = 1'b1;
    end
  endtask

  task automatic waitIdle(output bit tmo);
    int n;
    n = 0;
    while (dataOut[0] !== 1'b0 && n < 500) begin
      @(negedge clk); n++;
    end
    tmo = (n >= 500);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dataOut !== 8'h00) begin failures++; $display("FAIL reset_status got %h want 00", dataOut); end
    checks++; if (clkOe !== 1'b0) begin failures++; $display("FAIL reset_clk_oe got %b want 0", clkOe); end
    checks++; if (dataOe !== 1'b0) begin failures++; $display("FAIL reset_data_oe got %b want 0", dataOe); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b want 0", irq); end
    resetN = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ack_ed;
    logic [10:0] bits; logic [7:0] ms; bit tmo; int irq0;
    irq0 = irqCount;
    hostWrite(8'hED);
    checks++; if (dataOut !== 8'h01) begin failures++; $display("FAIL ed_busy got %h want 01", dataOut); end
    deviceRun(11, 1'b1, 0, 8'h00, bits, ms, tmo);
    waitIdle(tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL ed_timeout got %b want 0", tmo); end
    checks++; if (bits[0] !== 1'b0) begin failures++; $display("FAIL ed_start got %b want 0", bits[0]); end
    checks++; if (bits[8:1] !== 8'hED) begin failures++; $display("FAIL ed_data got %h want ed", bits[8:1]); end
    checks++; if (bits[9] !== 1'b1) begin failures++; $display("FAIL ed_parity got %b want 1", bits[9]); end
    checks++; if (bits[10] !== 1'b1) begin failures++; $display("FAIL ed_stop got %b want 1", bits[10]); end
    checks++; if (dataOut !== 8'h04) begin failures++; $display("FAIL ed_status got %h want 04", dataOut); end
    checks++; if (irqCount - irq0 !== 1) begin failures++; $display("FAIL ed_irq got %0d want 1", irqCount - irq0); end
  endtask

  task automatic test_inhibit;
    logic [10:0] bits; logic [7:0] ms; bit tmo; int n; int dHigh; logic lastD;
    hostWrite(8'h01);
    n = 0; dHigh = 0; lastD = 1'b0;
    while (clkOe === 1'b1 && n < 6000) begin
      n++;
      if (dataOe === 1'b1) dHigh++;
      lastD = dataOe;
      @(negedge clk);
    end
    checks++; if (n !== 5000) begin failures++; $display("FAIL inhibit_len got %0d want 5000", n); end
    checks++; if (dHigh !== 1 || lastD !== 1'b1) begin failures++; $display("FAIL inhibit_data got %0d/%b want 1/1", dHigh, lastD); end
    deviceRun(11, 1'b1, 0, 8'h00, bits, ms, tmo);
    waitIdle(tmo);
    checks++; if (bits[8:1] !== 8'h01) begin failures++; $display("FAIL x01_data got %h want 01", bits[8:1]); end
    checks++; if (bits[9] !== 1'b0) begin failures++; $display("FAIL x01_parity got %b want 0", bits[9]); end
    checks++; if (dataOut !== 8'h04) begin failures++; $display("FAIL x01_status got %h want 04", dataOut); end
  endtask

  task automatic test_nack;
    logic [10:0] bits; logic [7:0] ms; bit tmo; int irq0;
    irq0 = irqCount;
    hostWrite(8'hF4);
    checks++; if (dataOut !== 8'h01) begin failures++; $display("FAIL f4_busy got %h want 01", dataOut); end
    deviceRun(11, 1'b0, 0, 8'h00, bits, ms, tmo);
    waitIdle(tmo);
    checks++; if (bits[8:1] !== 8'hF4 || bits[9] !== 1'b0) begin failures++; $display("FAIL f4_frame got %h/%b want f4/0", bits[8:1], bits[9]); end
    checks++; if (dataOut !== 8'h02) begin failures++; $display("FAIL f4_status got %h want 02", dataOut); end
    checks++; if (irqCount - irq0 !== 1) begin failures++; $display("FAIL f4_irq got %0d want 1", irqCount - irq0); end
    // Stray device clocks while idle must not change anything.
    repeat (3) begin
      devClk = 1'b0; repeat (10) @(negedge clk);
      devClk = 1'b1; repeat (10) @(negedge clk);
    end
    checks++; if (dataOut !== 8'h02 || clkOe !== 1'b0 || dataOe !== 1'b0) begin
      failures++; $display("FAIL idle_edges got %h/%b/%b want 02/0/0", dataOut, clkOe, dataOe);
    end
    checks++; if (irqCount - irq0 !== 1) begin failures++; $display("FAIL idle_irq got %0d want 1", irqCount - irq0); end
  endtask

  task automatic test_busy_write;
    logic [10:0] bits; logic [7:0] ms; bit tmo;
    hostWrite(8'hAA);
    deviceRun(11, 1'b1, 4, 8'h55, bits, ms, tmo);
    checks++; if (ms !== 8'h01) begin failures++; $display("FAIL busywr_status got %h want 01", ms); end
    waitIdle(tmo);
    checks++; if (bits[8:1] !== 8'hAA || bits[9] !== 1'b1) begin failures++; $display("FAIL busywr_frame got %h/%b want aa/1", bits[8:1], bits[9]); end
    checks++; if (dataOut !== 8'h04) begin failures++; $display("FAIL busywr_end got %h want 04", dataOut); end
  endtask

  task automatic test_glitch;
    logic [10:0] bits; logic [7:0] ms; bit tmo; int n;
    hostWrite(8'hED);
    n = 0;
    while (!(clkOe === 1'b0 && dataOe === 1'b1) && n < 10000) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    devClk = 1'b0;
    @(negedge clk);
    devClk = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (dataOe !== 1'b1) begin failures++; $display("FAIL glitch_hold got %b want 1", dataOe); end
    deviceRun(11, 1'b1, 0, 8'h00, bits, ms, tmo);
    waitIdle(tmo);
    checks++; if (bits[8:1] !== 8'hED || dataOut !== 8'h04) begin failures++; $display("FAIL glitch_frame got %h/%h want ed/04", bits[8:1], dataOut); end
  endtask

  task automatic test_timeout;
    int n; int irq0;
    irq0 = irqCount;
    hostWrite(8'h3C);
    n = 0;
    while (clkOe !== 1'b0 && n < 6000) begin @(negedge clk); n++; end
`ifdef PS2_HOST_TX_TIMEOUT_EN
    n = 0;
    while (dataOe === 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (n !== 2000) begin failures++; $display("FAIL timeout_len got %0d want 2000", n); end
    checks++; if (clkOe !== 1'b0 || dataOut !== 8'h02) begin failures++; $display("FAIL timeout_state got %b/%h want 0/02", clkOe, dataOut); end
    repeat (3) @(negedge clk);
    checks++; if (irqCount - irq0 !== 1) begin failures++; $display("FAIL timeout_irq got %0d want 1", irqCount - irq0); end
`else
    repeat (3000) @(negedge clk);
    checks++; if (dataOut !== 8'h01 || dataOe !== 1'b1) begin failures++; $display("FAIL nowd_busy got %h/%b want 01/1", dataOut, dataOe); end
    checks++; if (irqCount - irq0 !== 0) begin failures++; $display("FAIL nowd_irq got %0d want 0", irqCount - irq0); end
`endif
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [10:0] bits; logic [7:0] ms; bit tmo; int irq0;
    irq0 = irqCount;
    hostWrite(8'hED);
    deviceRun(5, 1'b1, 0, 8'h00, bits, ms, tmo);
    checks++; if (dataOe !== 1'b1 || dataOut !== 8'h01) begin failures++; $display("FAIL mid_bit4 got %b/%h want 1/01", dataOe, dataOut); end
    #3 resetN = 1'b0;
    #1;
    checks++; if (clkOe !== 1'b0 || dataOe !== 1'b0 || dataOut !== 8'h00) begin
      failures++; $display("FAIL mid_async got %b/%b/%h want 0/0/00", clkOe, dataOe, dataOut);
    end
    repeat (4) @(negedge clk);
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (irqCount - irq0 !== 0) begin failures++; $display("FAIL mid_irq got %0d want 0", irqCount - irq0); end
    hostWrite(8'hED);
    deviceRun(11, 1'b1, 0, 8'h00, bits, ms, tmo);
    waitIdle(tmo);
    checks++; if (bits[8:1] !== 8'hED || dataOut !== 8'h04) begin failures++; $display("FAIL mid_retry got %h/%h want ed/04", bits[8:1], dataOut); end
    checks++; if (irqCount - irq0 !== 1) begin failures++; $display("FAIL mid_retry_irq got %0d want 1", irqCount - irq0); end
  endtask

  initial begin
    test_reset();
    test_ack_ed();
    test_inhibit();
    test_nack();
    test_busy_write();
    test_glitch();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
